wind_input_conditioner: RTL
===========================

# wind_input_conditioner

Input conditioning stage directly upstream of the hazard-lights FSM. It takes the two raw, asynchronous wind-direction switches and synchronizes and debounces them. It then filters out the illegal code and delivers a clean, stable `wind` code to the FSM's `wind` input, plus a one-cycle change strobe and an invalid flag for status display. All logic runs on the same divided clock as the FSM.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive clk cycles a synchronized switch value must hold before it is accepted; legal range 1..15.
- `clk`  input  1  single clock for the block; the same `clkSelect` that drives the FSM.
- `reset`  input  1  asynchronous, active-low reset; wired directly to `KEY[0]`.
- `sw_raw`  input  2  raw switch code from `SW[1:0]`. 00 = calm, 01 = right-to-left, 10 = left-to-right, 11 = illegal.
- `wind`  output  2  conditioned wind code to the FSM; always 00, 01 or 10.
- `wind_change`  output  1  one-cycle pulse on the same edge that `wind` takes a new value.
- `invalid`  output  1  level; high while the debounced switch code is 11.

## Operation
- **Synchronizer:** two flops on `sw_raw`, reset to 00. Only the second-stage value (`sync`) is used downstream.
- **Debouncer:**
  - Holds a `candidate` register (2 b) and a saturating counter `cnt` (4 b).
  - FSM states are SETTLED and COUNTING.
  - SETTLED: if `sync` ≠ `candidate`, load `candidate` ← `sync`, set `cnt` ← 1, and go to COUNTING.
  - COUNTING: if `sync` ≠ `candidate`, reload `candidate` and set `cnt` ← 1 (restart).
  - COUNTING: else if `cnt` = `STABLE_CYCLES`, commit `candidate` to `stable` and go to SETTLED.
  - COUNTING: else `cnt` ← `cnt` + 1.
  - A bounce shorter than `STABLE_CYCLES` cycles never commits.
- **Filter** (acts on the commit edge):
  - `stable` = 00/01/10: `wind` ← `stable`, `invalid` ← 0. `wind_change` pulses iff the new `wind` differs from the old `wind`.
  - `stable` = 11: `invalid` ← 1. `wind` is handled per Configuration.
- No commit occurs when `candidate` equals the current `stable`, so there is no pulse. Example: 01 → 11 → 01 within the debounce window.
- Leaving 11 for the legal code already on `wind` clears `invalid` with no `wind_change` pulse.

## Timing
- **Reset** (async, while `reset` = 0):
  - Both sync flops, `candidate`, `stable` = 00.
  - `cnt` = 0; state SETTLED.
  - `wind` = 00, `wind_change` = 0, `invalid` = 0.
- Reset may assert at any point, including mid-count. It clears everything immediately, with no partial commit. Release is sampled on the next rising clk edge.
- **Latency:** if `sw_raw` changes before edge k and then holds, `wind`, `wind_change` and `invalid` update at edge k + 2 + `STABLE_CYCLES`. With the default this is edge k+6.
- `wind_change` is high for exactly one cycle per accepted change, and never high two cycles in a row. The minimum spacing between pulses is `STABLE_CYCLES` + 1 cycles.
- A `sync` change on the exact edge where `cnt` reaches `STABLE_CYCLES` wins: the counter restarts and nothing commits.
- All outputs are registered, with no combinational path from `sw_raw`.

## Configuration
- Macro: `WIND_INVALID_HOLD_EN`.
- **Defined:** a committed 11 leaves `wind` at its last legal value with no `wind_change`; `invalid` = 1.
- **Undefined:** a committed 11 forces `wind` to 00 (calm); `invalid` = 1. `wind_change` pulses iff the previous `wind` ≠ 00.

## Test plan
- **Reset and clean change:** reset low for 2 cycles, then `sw_raw` = 01 held. Required: `wind` = 00 and `invalid` = 0 through edge k+5; `wind` = 01 with a single `wind_change` pulse at edge k+6.
- **Glitch rejection:** `wind` = 01 settled, then `sw_raw` pulses to 10 for 3 cycles and returns to 01. Required: `wind` stays 01 and `wind_change` never asserts.
- **Direction swap:** 01 → 10 held. Required: `wind` = 10 at k+6, one pulse. Then 10 → 00: `wind` = 00 at k+6, one pulse.
- **Illegal code:** `wind` = 10, then `sw_raw` = 11 held. Required with `WIND_INVALID_HOLD_EN` defined: `invalid` = 1 at k+6, `wind` = 10, no pulse. Required with it undefined: `wind` = 00 and one pulse at k+6. Then `sw_raw` = 10: `invalid` = 0 at k+6, with no pulse when the macro is defined.
- **Reset mid-count:** `sw_raw` = 01 from 00; assert reset at edge k+4 and release at k+5 with `sw_raw` still 01. Required: all outputs 0 immediately on reset; `wind` = 01 with one pulse at the full latency measured from release, not earlier.

Source files
------------

// File: rtl/wind_input_conditioner.sv
// Synchronizes, debounces and filters the raw wind-direction switches feeding the hazard-lights FSM.
// Optional macro WIND_INVALID_HOLD_EN: a committed illegal code keeps the last legal wind instead of forcing calm.
module wind_input_conditioner #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_raw,
  output logic [1:0] wind,
  output logic       wind_change,
  output logic       invalid
);

  typedef enum logic {SETTLED, COUNTING} state_t;

  localparam logic [3:0] STABLE_LIMIT = 4'(STABLE_CYCLES);
  localparam logic [1:0] CODE_CALM    = 2'b00;
  localparam logic [1:0] CODE_ILLEGAL = 2'b11;

  state_t     state;
  logic [1:0] sync_meta;
  logic [1:0] sync;
  logic [1:0] candidate;
  logic [1:0] stable;
  logic [3:0] cnt;
  logic [1:0] filtered_wind;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 2'b00;
      sync      <= 2'b00;
    end else begin
      sync_meta <= sw_raw;
      sync      <= sync_meta;
    end
  end

  // Wind value the FSM should see if the current candidate were accepted.
  always_comb begin
    filtered_wind = candidate;
    if (candidate == CODE_ILLEGAL) begin
`ifdef WIND_INVALID_HOLD_EN
      filtered_wind = wind;
`else
      filtered_wind = CODE_CALM;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SETTLED;
      candidate   <= 2'b00;
      stable      <= 2'b00;
      cnt         <= 4'd0;
      wind        <= 2'b00;
      wind_change <= 1'b0;
      invalid     <= 1'b0;
    end else begin
      wind_change <= 1'b0;
      case (state)
        SETTLED: begin
          if (sync != candidate) begin
            candidate <= sync;
            cnt       <= 4'd1;
            state     <= COUNTING;
          end
        end
        COUNTING: begin
          if (sync != candidate) begin
            candidate <= sync;
            cnt       <= 4'd1;
          end else if (cnt == STABLE_LIMIT) begin
            // A bounce that returned to the accepted code settles without touching the outputs.
            state <= SETTLED;
            if (candidate != stable) begin
              stable      <= candidate;
              wind        <= filtered_wind;
              wind_change <= (filtered_wind != wind);
              invalid     <= (candidate == CODE_ILLEGAL);
            end
          end else if (cnt != 4'hF) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= SETTLED;
      endcase
    end
  end

endmodule
